// File: rtl/msg_unpack.sv
// msg_unpack: receive-side message deframer.
// Collects a command byte plus its optional argument bytes from the UART
// receiver into cmd/a1/a2/a3. The command is flagged (cmd_ready) as soon as
// it arrives, so the consumer can start arbitrating while arguments are
// still outstanding (busy). Stalled frames are aborted on a timeout.
//
// Ports:
//   clk_sys     system clock
//   rst_n       asynchronous active-low reset
//   uart_data   received byte, bit 0 is the MSB
//   uart_ready  high while uart_data is valid; a rising edge marks a byte
//   reset       frame consumed, return to IDLE (synchronous)
//   cmd_ready   command byte held in cmd
//   busy        argument bytes still outstanding
//   cmd/a1/a2/a3  command and argument registers (bit 0 is the MSB)
//   err         one-cycle pulse on timeout abort
//   drop        one-cycle pulse when a byte is discarded
//
// state | meaning
// IDLE  | waiting for a command byte
// A1    | waiting for argument 1
// A2H   | waiting for argument 2 high byte
// A2L   | waiting for argument 2 low byte
// A3H   | waiting for argument 3 high byte
// A3L   | waiting for argument 3 low byte
// DONE  | frame complete, outputs held, further bytes dropped
module msg_unpack #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [0:7]  uart_data,
  input  logic        uart_ready,
  input  logic        reset,
  output logic        cmd_ready,
  output logic        busy,
  output logic [0:7]  cmd,
  output logic [0:7]  a1,
  output logic [0:15] a2,
  output logic [0:15] a3,
  output logic        err,
  output logic        drop
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  // Loaded with T-1 and fired at 1 so err appears exactly T cycles after
  // the strobe that loaded it.
  localparam logic [CW-1:0] LP_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_A1, S_A2H, S_A2L, S_A3H, S_A3L, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic          r_uart_ready_q;
  logic          r_cmd_ready, r_busy, r_err, r_drop;
  logic [0:7]    r_cmd, r_a1;
  logic [0:15]   r_a2, r_a3;
  logic [CW-1:0] r_tmo_cnt;

  logic w_strb, w_in_arg, w_tmo;
  logic w_cmd_ready, w_busy, w_err, w_drop, w_cnt_load;
  logic w_cap_cmd, w_cap_a1, w_cap_a2h, w_cap_a2l, w_cap_a3h, w_cap_a3l;

  function automatic state_t after_a1(input logic p2, input logic p3);
    return p2 ? S_A2H : (p3 ? S_A3H : S_DONE);
  endfunction

  function automatic state_t after_a2(input logic p3);
    return p3 ? S_A3H : S_DONE;
  endfunction

  assign w_strb   = uart_ready & ~r_uart_ready_q;
  assign w_in_arg = (r_state == S_A1)  || (r_state == S_A2H) || (r_state == S_A2L) ||
                    (r_state == S_A3H) || (r_state == S_A3L);
  assign w_tmo    = w_in_arg && (r_tmo_cnt == LP_ONE);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = r_cmd_ready;
    w_busy      = r_busy;
    w_err       = 1'b0;
    w_drop      = 1'b0;
    w_cnt_load  = 1'b0;
    w_cap_cmd   = 1'b0;
    w_cap_a1    = 1'b0;
    w_cap_a2h   = 1'b0;
    w_cap_a2l   = 1'b0;
    w_cap_a3h   = 1'b0;
    w_cap_a3l   = 1'b0;
    if (reset) begin
      w_next      = S_IDLE;
      w_cmd_ready = 1'b0;
      w_busy      = 1'b0;
      w_drop      = w_strb;
    end else if (w_tmo) begin
      w_next      = S_IDLE;
      w_cmd_ready = 1'b0;
      w_busy      = 1'b0;
      w_err       = 1'b1;
      w_drop      = w_strb;
    end else if (w_strb) begin
      w_cnt_load = 1'b1;
      case (r_state)
        S_IDLE: begin
          w_cap_cmd   = 1'b1;
          w_cmd_ready = 1'b1;
          w_next      = uart_data[1] ? S_A1 : after_a1(uart_data[2], uart_data[3]);
        end
        S_A1: begin
          w_cap_a1 = 1'b1;
          w_next   = after_a1(r_cmd[2], r_cmd[3]);
        end
        S_A2H: begin
          w_cap_a2h = 1'b1;
          w_next    = S_A2L;
        end
        S_A2L: begin
          w_cap_a2l = 1'b1;
          w_next    = after_a2(r_cmd[3]);
        end
        S_A3H: begin
          w_cap_a3h = 1'b1;
          w_next    = S_A3L;
        end
        S_A3L: begin
          w_cap_a3l = 1'b1;
          w_next    = S_DONE;
        end
        S_DONE: begin
          w_drop     = 1'b1;
          w_cnt_load = 1'b0;
        end
        default: w_next = S_IDLE;
      endcase
      if (r_state != S_DONE) w_busy = (w_next != S_DONE);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_uart_ready_q <= 1'b1;  // a level already high at release is not a byte
      r_cmd_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_err          <= 1'b0;
      r_drop         <= 1'b0;
      r_tmo_cnt      <= '0;
    end else begin
      r_uart_ready_q <= uart_ready;
      r_cmd_ready    <= w_cmd_ready;
      r_busy         <= w_busy;
      r_err          <= w_err;
      r_drop         <= w_drop;
      if (w_cnt_load)    r_tmo_cnt <= LP_LOAD;
      else if (w_in_arg) r_tmo_cnt <= r_tmo_cnt - LP_ONE;
    end
  end

  // Data registers survive the synchronous reset; downstream keeps using them.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd <= '0;
      r_a1  <= '0;
      r_a2  <= '0;
      r_a3  <= '0;
    end else begin
      if (w_cap_cmd) begin
        r_cmd <= uart_data;
        r_a1  <= '0;
        r_a2  <= '0;
        r_a3  <= '0;
      end
      if (w_cap_a1)  r_a1       <= uart_data;
      if (w_cap_a2h) r_a2[0:7]  <= uart_data;
      if (w_cap_a2l) r_a2[8:15] <= uart_data;
      if (w_cap_a3h) r_a3[0:7]  <= uart_data;
      if (w_cap_a3l) r_a3[8:15] <= uart_data;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign err       = r_err;
  assign drop      = r_drop;
  assign cmd       = r_cmd;
  assign a1        = r_a1;
  assign a2        = r_a2;
  assign a3        = r_a3;

endmodule
